// File: rtl/fetch_sequencer_if.sv
// Handshake and bus bundle between the fetch sequencer and its driver.
// The master side drives control and LUT writes; the slave side owns PC state.
interface fetch_sequencer_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 6,
  parameter int CNT_W  = 16
);
  logic              Start;
  logic [PC_W-1:0]   StartAddr;
  logic              Jen;
  logic [7:0]        Jptr;
  logic              BranchCond;
  logic              Done;
  logic              LutWe;
  logic [LUT_AW-1:0] LutWaddr;
  logic [PC_W-1:0]   LutWdata;
  logic [PC_W-1:0]   Prog_ctr;
  logic              Fetch_en;
  logic              Ack;
  logic [CNT_W-1:0]  Cycle_cnt;

  modport master (
    output Start, StartAddr, Jen, Jptr,
    output BranchCond, Done,
    output LutWe, LutWaddr, LutWdata,
    input  Prog_ctr, Fetch_en, Ack,
    input  Cycle_cnt
  );

  modport slave (
    input  Start, StartAddr, Jen, Jptr,
    input  BranchCond, Done,
    input  LutWe, LutWaddr, LutWdata,
    output Prog_ctr, Fetch_en, Ack,
    output Cycle_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter sequencer: start/ack handshake, LUT-resolved
// branches, and a saturating count of RUN cycles.
module fetch_sequencer #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 6,
  parameter int CNT_W  = 16
) (
  input  logic Clk,
  input  logic Reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam int LUT_N = 2 ** LUT_AW;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic [PC_W-1:0]  r_lut [LUT_N];

  logic [LUT_AW-1:0] w_idx;
  logic [PC_W-1:0]   w_tgt;
  logic              w_take;
  logic              w_unused;

  assign w_idx    = bus.Jptr[LUT_AW-1:0];
  assign w_unused = &{1'b0, bus.Jptr[7:LUT_AW]};
  assign w_tgt    = r_lut[w_idx];
  assign w_take   = bus.Jen & bus.BranchCond;

  assign bus.Prog_ctr  = r_pc;
  assign bus.Fetch_en  = (r_state == S_RUN);
  assign bus.Ack       = r_ack;
  assign bus.Cycle_cnt = r_cnt;

  // LUT read above uses pre-edge contents, so a
  // same-cycle write is seen only from the next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      for (int i = 0; i < LUT_N; i++)
        r_lut[i] <= '0;
    end else begin
      if (bus.LutWe)
        r_lut[bus.LutWaddr] <= bus.LutWdata;
      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.Start) begin
            r_pc    <= bus.StartAddr;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
          if (bus.Done) begin
            r_state <= S_HALT;
            r_ack   <= 1'b1;
          end else if (w_take) begin
            r_pc <= w_tgt;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencer.
module tb_fetch_sequencer;
  localparam int PC_W   = 10;
  localparam int LUT_AW = 6;
  localparam int CNT_W  = 16;
  localparam int PC_M   = 2 ** PC_W;
  localparam int CNT_MX = 2 ** CNT_W - 1;

  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_sequencer_if #(
    .PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)
  ) bus ();

  fetch_sequencer #(
    .PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // model: 0=IDLE 1=RUN 2=HALTED
  int m_mode;
  int m_pc;
  int m_cnt;
  int m_ack;
  int m_lut [2**LUT_AW];

  task automatic clr_in();
    bus.Start      = 0;
    bus.StartAddr  = '0;
    bus.Jen        = 0;
    bus.Jptr       = '0;
    bus.BranchCond = 0;
    bus.Done       = 0;
    bus.LutWe      = 0;
    bus.LutWaddr   = '0;
    bus.LutWdata   = '0;
  endtask

  task automatic step();
    int tgt;
    tgt = m_lut[int'(bus.Jptr) % (2**LUT_AW)];
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_ack = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      if (m_mode == 1) begin
        if (m_cnt < CNT_MX) m_cnt = m_cnt + 1;
        if (bus.Done) begin
          m_mode = 2; m_ack = 1;
        end else if (bus.Jen && bus.BranchCond) begin
          m_pc = tgt;
        end else begin
          m_pc = (m_pc + 1) % PC_M;
        end
      end else if (bus.Start) begin
        m_pc = int'(bus.StartAddr);
        m_cnt = 0; m_ack = 0; m_mode = 1;
      end
      if (bus.LutWe)
        m_lut[int'(bus.LutWaddr)] = int'(bus.LutWdata);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input int addr);
    clr_in();
    bus.Done = 1;
    step();
    clr_in();
    bus.Start = 1;
    bus.StartAddr = PC_W'(addr);
    step();
    clr_in();
  endtask

  task automatic test_reset();
    clr_in();
    Reset = 1;
    step();
    step();
    Reset = 0;
    n_cmp++;
    if (bus.Prog_ctr !== 0 || bus.Fetch_en !== 0 ||
        bus.Ack !== 0 || bus.Cycle_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset pc=%0d fe=%0b ack=%0b cnt=%0d want all 0",
        bus.Prog_ctr, bus.Fetch_en, bus.Ack, bus.Cycle_cnt);
    end
  endtask

  task automatic test_start();
    clr_in();
    bus.Start = 1;
    bus.StartAddr = 10'd5;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd5 || bus.Fetch_en !== 1 ||
        bus.Ack !== 0) begin
      n_bad++;
      $display("FAIL start pc=%0d fe=%0b ack=%0b want 5 1 0",
        bus.Prog_ctr, bus.Fetch_en, bus.Ack);
    end
    repeat (3) step();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd8 || bus.Cycle_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL seq pc=%0d cnt=%0d want 8 3",
        bus.Prog_ctr, bus.Cycle_cnt);
    end
  endtask

  task automatic test_branch();
    clr_in();
    bus.LutWe = 1; bus.LutWaddr = 6'd3; bus.LutWdata = 10'd40;
    step();
    go(10);
    bus.Jen = 1; bus.BranchCond = 1; bus.Jptr = 8'h03;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd40) begin
      n_bad++;
      $display("FAIL br_taken pc=%0d want 40", bus.Prog_ctr);
    end
    go(10);
    bus.Jen = 1; bus.BranchCond = 0; bus.Jptr = 8'h03;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd11) begin
      n_bad++;
      $display("FAIL br_nottaken pc=%0d want 11", bus.Prog_ctr);
    end
    go(10);
    bus.Jen = 1; bus.BranchCond = 1; bus.Jptr = 8'hC3;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd40) begin
      n_bad++;
      $display("FAIL br_upper pc=%0d want 40", bus.Prog_ctr);
    end
  endtask

  task automatic test_done();
    logic [CNT_W-1:0] c0;
    go(20);
    c0 = bus.Cycle_cnt;
    bus.Done = 1; bus.Jen = 1; bus.BranchCond = 1; bus.Jptr = 8'h03;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd20 || bus.Ack !== 1 ||
        bus.Fetch_en !== 0 || bus.Cycle_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL done pc=%0d ack=%0b fe=%0b cnt=%0d want 20 1 0 1 (c0=%0d)",
        bus.Prog_ctr, bus.Ack, bus.Fetch_en, bus.Cycle_cnt, c0);
    end
    bus.Jen = 1; bus.BranchCond = 1;
    repeat (2) step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd20 || bus.Cycle_cnt !== 16'd1 ||
        bus.Ack !== 1) begin
      n_bad++;
      $display("FAIL halt_hold pc=%0d cnt=%0d ack=%0b want 20 1 1",
        bus.Prog_ctr, bus.Cycle_cnt, bus.Ack);
    end
    bus.Start = 1; bus.StartAddr = 10'd0;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 0 || bus.Ack !== 0 ||
        bus.Cycle_cnt !== 0 || bus.Fetch_en !== 1) begin
      n_bad++;
      $display("FAIL restart pc=%0d ack=%0b cnt=%0d fe=%0b want 0 0 0 1",
        bus.Prog_ctr, bus.Ack, bus.Cycle_cnt, bus.Fetch_en);
    end
  endtask

  task automatic test_lut_same_cycle();
    clr_in();
    bus.LutWe = 1; bus.LutWaddr = 6'd2; bus.LutWdata = 10'd7;
    step();
    go(30);
    bus.LutWe = 1; bus.LutWaddr = 6'd2; bus.LutWdata = 10'd50;
    bus.Jen = 1; bus.BranchCond = 1; bus.Jptr = 8'h02;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd7) begin
      n_bad++;
      $display("FAIL lut_old pc=%0d want 7", bus.Prog_ctr);
    end
    bus.Jen = 1; bus.BranchCond = 1; bus.Jptr = 8'h02;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd50) begin
      n_bad++;
      $display("FAIL lut_new pc=%0d want 50", bus.Prog_ctr);
    end
  endtask

  task automatic test_wrap();
    go(1023);
    n_cmp++;
    if (bus.Prog_ctr !== 10'd1023) begin
      n_bad++;
      $display("FAIL wrap0 pc=%0d want 1023", bus.Prog_ctr);
    end
    step();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd0) begin
      n_bad++;
      $display("FAIL wrap1 pc=%0d want 0", bus.Prog_ctr);
    end
    step();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd1) begin
      n_bad++;
      $display("FAIL wrap2 pc=%0d want 1", bus.Prog_ctr);
    end
    bus.Start = 1; bus.StartAddr = 10'd100;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd2 || bus.Cycle_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL start_in_run pc=%0d cnt=%0d want 2 3",
        bus.Prog_ctr, bus.Cycle_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    go(30);
    Reset = 1;
    step();
    Reset = 0;
    n_cmp++;
    if (bus.Prog_ctr !== 0 || bus.Fetch_en !== 0 || bus.Ack !== 0) begin
      n_bad++;
      $display("FAIL reset_run pc=%0d fe=%0b ack=%0b want 0 0 0",
        bus.Prog_ctr, bus.Fetch_en, bus.Ack);
    end
    go(10);
    bus.Jen = 1; bus.BranchCond = 1; bus.Jptr = 8'h03;
    step();
    clr_in();
    n_cmp++;
    if (bus.Prog_ctr !== 10'd0) begin
      n_bad++;
      $display("FAIL lut_cleared pc=%0d want 0", bus.Prog_ctr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      Reset          = ($urandom_range(0, 99) == 0);
      bus.Start      = ($urandom_range(0, 7) == 0);
      bus.StartAddr  = PC_W'($urandom_range(0, PC_M - 1));
      bus.Done       = ($urandom_range(0, 15) == 0);
      bus.Jen        = ($urandom_range(0, 2) == 0);
      bus.BranchCond = 1'($urandom);
      bus.Jptr       = 8'($urandom);
      bus.LutWe      = ($urandom_range(0, 3) == 0);
      bus.LutWaddr   = LUT_AW'($urandom);
      bus.LutWdata   = PC_W'($urandom);
      step();
      n_cmp++;
      if (bus.Prog_ctr !== PC_W'(m_pc) ||
          bus.Fetch_en !== (m_mode == 1) ||
          bus.Ack !== 1'(m_ack) ||
          bus.Cycle_cnt !== CNT_W'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand[%0d] pc=%0d fe=%0b ack=%0b cnt=%0d want %0d %0b %0d %0d",
          n, bus.Prog_ctr, bus.Fetch_en, bus.Ack, bus.Cycle_cnt,
          m_pc, (m_mode == 1), m_ack, m_cnt);
      end
    end
    Reset = 0;
    clr_in();
  endtask

  initial begin
    Reset = 1;
    clr_in();
    #1;
    test_reset();
    test_start();
    test_branch();
    test_done();
    test_lut_same_cycle();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of the instruction decoder: owns the program counter and drives the instruction-ROM address every cycle.
- Consumes the decoder's jump enable, jump pointer and done outputs, plus the ALU branch-condition flag.
- Resolves taken branches through a writable jump-target lookup table (LUT), indexed by the pointer field.
- Runs a start/ack handshake with the testbench/top level and counts executed cycles.

Parameters:
- PC_W, 10, program-counter width; instruction ROM depth is 2^PC_W.
- LUT_AW, 6, jump-LUT address width; LUT has 2^LUT_AW entries of PC_W bits.
- CNT_W, 16, cycle-counter width.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin program execution. Sampled in IDLE/HALTED only.
- StartAddr  in  PC_W  first instruction address, loaded on an accepted Start.
- Jen  in  1  jump enable from decoder.
- Jptr  in  8  jump pointer from decoder; only bits [LUT_AW-1:0] are used.
- BranchCond  in  1  ALU condition flag; a branch is taken only when Jen=1 and BranchCond=1.
- Done  in  1  halt indication from decoder.
- LutWe  in  1  jump-LUT write enable.
- LutWaddr  in  LUT_AW  jump-LUT write address.
- LutWdata  in  PC_W  jump-LUT write data (target PC).
- Prog_ctr  out  PC_W  instruction-ROM address.
- Fetch_en  out  1  high when Prog_ctr addresses a live instruction (state RUN).
- Ack  out  1  program finished; held until next accepted Start.
- Cycle_cnt  out  CNT_W  number of RUN cycles since the last accepted Start.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-run):
  - state=IDLE; Prog_ctr=0, Fetch_en=0, Ack=0, Cycle_cnt=0.
  - All LUT entries cleared to 0.
- States: IDLE, RUN, HALTED. Fetch_en = (state==RUN), decoded combinationally from state.
- IDLE:
  - Start=1 -> next edge: Prog_ctr<=StartAddr, Cycle_cnt<=0, Ack<=0, state<=RUN.
  - Jen and Done ignored.
- RUN: the decoder decodes the ROM word at the current Prog_ctr in the same cycle (combinational ROM). Priority at each edge:
  1. Done=1 -> state<=HALTED, Ack<=1, Prog_ctr holds (points at the done instruction).
  2. Jen=1 and BranchCond=1 -> Prog_ctr<=LUT[Jptr[LUT_AW-1:0]].
  3. Otherwise -> Prog_ctr<=Prog_ctr+1, wrapping mod 2^PC_W (max value -> 0).
  - Jen=1 with BranchCond=0 -> fall-through, Prog_ctr+1.
  - Cycle_cnt increments by 1 on every RUN cycle, including the Done cycle. Saturates at 2^CNT_W-1; no wrap.
  - Start is ignored in RUN.
- HALTED:
  - Ack=1, Prog_ctr and Cycle_cnt hold.
  - Start=1 -> identical to the IDLE transition (Ack clears on that edge).
- Latency:
  - Start to first fetch: 1 cycle.
  - Branch resolution: 0 bubble cycles; the target is fetched the cycle after the branch instruction.
- LUT:
  - Write on the rising edge when LutWe=1; allowed in any state.
  - Read is combinational. A same-cycle write and branch to the same entry uses the OLD value; the new value is visible from the next cycle.
- Jptr bits [7:LUT_AW] are ignored (no error).

Test Plan:
- Reset, then Start=1 with StartAddr=5 for 1 cycle -> next cycle Prog_ctr=5, Fetch_en=1, Ack=0; after 3 more cycles with no Jen/Done, Prog_ctr=8 and Cycle_cnt=3.
- Write LUT[3]=40, run at PC=10, pulse Jen=1/BranchCond=1/Jptr=8'h03 -> next Prog_ctr=40. Repeat with BranchCond=0 -> Prog_ctr=11. Repeat with Jptr=8'hC3 -> Prog_ctr=40 (upper bits ignored).
- At Prog_ctr=20 assert Done=1 and Jen=1 simultaneously -> state HALTED, Prog_ctr stays 20, Ack=1, Fetch_en=0, Cycle_cnt frozen. Subsequent Start with StartAddr=0 -> Ack=0, Prog_ctr=0, Cycle_cnt=0.
- Same-cycle LutWe to entry 2 (old 7, new 50) and taken branch Jptr=2 -> Prog_ctr=7. A second branch to entry 2 a cycle later -> Prog_ctr=50.
- StartAddr=1023 (PC_W=10), run 2 cycles -> Prog_ctr sequence 1023, 0, 1. Start asserted during RUN -> no effect on Prog_ctr.
- Reset asserted at Prog_ctr=30 mid-RUN -> next edge Prog_ctr=0, Fetch_en=0, Ack=0, LUT entries read 0.
